// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, opcode map, shifter modes, flag bundle.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 6;

  // Opcode map shared by the ID decoder, the EX operand mux and this ALU.
  typedef enum logic [OP_W-1:0] {
    OP_NOP  = 6'h00,
    OP_ADD  = 6'h01,
    OP_SUB  = 6'h02,
    OP_AND  = 6'h03,
    OP_OR   = 6'h04,
    OP_XOR  = 6'h05,
    OP_NOR  = 6'h06,
    OP_SLL  = 6'h07,
    OP_SRL  = 6'h08,
    OP_SRA  = 6'h09,
    OP_SLT  = 6'h0A,
    OP_SLTU = 6'h0B,
    OP_LUI  = 6'h0C,
    OP_LDW  = 6'h10,
    OP_SDW  = 6'h11
  } alu_op_e;

  typedef enum logic [1:0] {
    SH_SLL = 2'd0,
    SH_SRL = 2'd1,
    SH_SRA = 2'd2
  } shift_mode_e;

  typedef struct packed {
    logic zf;
    logic cf;
    logic of;
  } flags_t;

  // Bit reversal lets the shifter implement left shifts on the right-shift network.
  function automatic logic [DATA_W-1:0] bitrev(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) r[i] = v[DATA_W-1-i];
    return r;
  endfunction

endpackage

// File: rtl/alu_if.sv
// Operand/result bundle between the EX stage and the ALU.
// Latency: wires only.
// Backpressure: none; a new operand set is presented every cycle.
interface alu_if;
  import alu_pkg::*;

  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [OP_W-1:0]   opcode;
  logic [DATA_W-1:0] alu_out;
  logic              zf;
  logic              cf;
  logic              of;
  logic              zf_q;
  logic              cf_q;
  logic              of_q;

  modport master (
    output a, b, opcode,
    input  alu_out, zf, cf, of, zf_q, cf_q, of_q
  );

  modport slave (
    input  a, b, opcode,
    output alu_out, zf, cf, of, zf_q, cf_q, of_q
  );

endinterface

// File: rtl/alu_shifter.sv
// 32-bit barrel shifter for SLL/SRL/SRA using a single right-shift network.
// Latency: combinational, zero cycles.
// Backpressure: none.
module alu_shifter
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [4:0]        shamt_i,
  input  shift_mode_e       mode_i,
  output logic [DATA_W-1:0] res_o
);

  logic              is_left;
  logic              fill;
  logic [DATA_W-1:0] stage;

  assign is_left = (mode_i == SH_SLL);
  assign fill    = (mode_i == SH_SRA) & a_i[DATA_W-1];

  // Five log-steps of right shift; left shifts are bit-reversed in and out.
  always_comb begin
    stage = is_left ? bitrev(a_i) : a_i;
    for (int i = 0; i < 5; i++) begin
      if (shamt_i[i]) begin
        stage = (stage >> (1 << i)) |
                ({DATA_W{fill}} & ~({DATA_W{1'b1}} >> (1 << i)));
      end
    end
    res_o = is_left ? bitrev(stage) : stage;
  end

endmodule

// File: rtl/alu.sv
// EX-stage integer ALU with live zero/carry/overflow flags and a registered flag copy.
// Latency: result and live flags combinational; registered flags one cycle.
// Backpressure: none; accepts a new opcode and operand set every cycle.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic clk,
  input  logic rst_n,
  alu_if.slave bus
);

  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] sum_res;
  logic             add_of;
  logic             sub_of;
  logic [WIDTH-1:0] shift_res;
  shift_mode_e      shift_mode;
  logic [WIDTH-1:0] res;
  logic             cf_live;
  logic             of_live;
  flags_t           flags_d;
  flags_t           flags_q;

  // One shared adder: subtraction is a + ~b + 1, so carry-out high means no borrow.
  assign is_sub  = (bus.opcode == OP_SUB);
  assign b_eff   = is_sub ? ~bus.b : bus.b;
  assign sum     = {1'b0, bus.a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
  assign sum_res = sum[WIDTH-1:0];

  // Signed overflow: result sign disagrees with a when the effective operands share a sign.
  assign add_of = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) & (sum_res[WIDTH-1] != bus.a[WIDTH-1]);
  assign sub_of = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) & (sum_res[WIDTH-1] != bus.a[WIDTH-1]);

  // Shift direction/fill derived from the opcode; the result is only used for shift ops.
  always_comb begin
    shift_mode = SH_SRA;
    if (bus.opcode == OP_SLL)      shift_mode = SH_SLL;
    else if (bus.opcode == OP_SRL) shift_mode = SH_SRL;
  end

  alu_shifter u_shifter (
    .a_i     (bus.a),
    .shamt_i (bus.b[4:0]),
    .mode_i  (shift_mode),
    .res_o   (shift_res)
  );

  // Result and carry/overflow select; unknown opcodes fall through to zero with clear flags.
  always_comb begin
    res     = '0;
    cf_live = 1'b0;
    of_live = 1'b0;
    case (bus.opcode)
      OP_ADD, OP_LDW, OP_SDW: begin
        res     = sum_res;
        cf_live = sum[WIDTH];
        of_live = add_of;
      end
      OP_SUB: begin
        res     = sum_res;
        cf_live = ~sum[WIDTH];
        of_live = sub_of;
      end
      OP_AND:  res = bus.a & bus.b;
      OP_OR:   res = bus.a | bus.b;
      OP_XOR:  res = bus.a ^ bus.b;
      OP_NOR:  res = ~(bus.a | bus.b);
      OP_SLL, OP_SRL, OP_SRA: res = shift_res;
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      OP_SLTU: res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
      OP_LUI:  res = {bus.b[15:0], 16'h0000};
      default: res = '0;
    endcase
  end

  assign bus.alu_out = res;
  assign bus.zf      = (res == '0);
  assign bus.cf      = cf_live;
  assign bus.of      = of_live;

  assign flags_d.zf = bus.zf;
  assign flags_d.cf = cf_live;
  assign flags_d.of = of_live;

  // Flag register: snapshot of the live flags every edge, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flags_q <= '0;
    else        flags_q <= flags_d;
  end

  assign bus.zf_q = flags_q.zf;
  assign bus.cf_q = flags_q.cf;
  assign bus.of_q = flags_q.of;

endmodule

// File: tb/tb_alu.sv
// Testbench for alu: directed vector table, randomized vectors against a model, reset sequences.
// Latency: checks combinational outputs 1 time unit after driving, registered flags after an edge.
// Backpressure: none.
module tb_alu;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  alu_if bus ();

  alu #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam longint SMAX = 64'sh0000_0000_7FFF_FFFF;
  localparam longint SMIN = -64'sh0000_0000_8000_0000;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_out;
    logic        exp_zf;
    logic        exp_cf;
    logic        exp_of;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model written from the arithmetic rules with wide integer math.
  function automatic void ref_model(input logic [5:0] op, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] r,
                                    output logic c, output logic o);
    longint ua, ub, sa, sb, s;
    int     sh;
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b % 32);
    r = 32'h0; c = 1'b0; o = 1'b0;
    case (op)
      6'h01, 6'h10, 6'h11: begin
        s = ua + ub; r = s[31:0]; c = (s > 64'sh0000_0000_FFFF_FFFF);
        o = (sa + sb > SMAX) || (sa + sb < SMIN);
      end
      6'h02: begin
        s = ua - ub; r = s[31:0]; c = (ua < ub);
        o = (sa - sb > SMAX) || (sa - sb < SMIN);
      end
      6'h03: r = a & b;
      6'h04: r = a | b;
      6'h05: r = a ^ b;
      6'h06: r = ~(a | b);
      6'h07: r = a << sh;
      6'h08: r = a >> sh;
      6'h09: begin s = sa >>> sh; r = s[31:0]; end
      6'h0A: r = (sa < sb) ? 32'd1 : 32'd0;
      6'h0B: r = (ua < ub) ? 32'd1 : 32'd0;
      6'h0C: r = b * 32'd65536;
      default: r = 32'h0;
    endcase
  endfunction

  task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.opcode = op;
    bus.a      = a;
    bus.b      = b;
  endtask

  task automatic chk_live(input string name, input logic [31:0] out,
                          input logic z, input logic c, input logic o);
    chk({name, ".out"}, bus.alu_out, out);
    chk({name, ".zf"},  32'(bus.zf), 32'(z));
    chk({name, ".cf"},  32'(bus.cf), 32'(c));
    chk({name, ".of"},  32'(bus.of), 32'(o));
  endtask

  task automatic chk_reg(input string name, input logic z, input logic c, input logic o);
    chk({name, ".zf_q"}, 32'(bus.zf_q), 32'(z));
    chk({name, ".cf_q"}, 32'(bus.cf_q), 32'(c));
    chk({name, ".of_q"}, 32'(bus.of_q), 32'(o));
  endtask

  initial begin
    logic [5:0]  op;
    logic [31:0] ra, rb, r;
    logic        c, o;
    logic [5:0]  valid_ops[15];

    checks = 0;
    errors = 0;
    rst_n  = 1'b1;
    drive(6'h00, 32'h0, 32'h0);

    // Reset state of the flag register.
    #2 rst_n = 1'b0;
    #1 chk_reg("reset", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors.
    vecs.push_back('{"add_wrap",  6'h01, 32'hFFFF_FFFF, 32'h1,          32'h0,          1, 1, 0});
    vecs.push_back('{"sub_ovf",   6'h02, 32'h8000_0000, 32'h1,          32'h7FFF_FFFF,  0, 0, 1});
    vecs.push_back('{"sub_brw",   6'h02, 32'h3,         32'h5,          32'hFFFF_FFFE,  0, 1, 0});
    vecs.push_back('{"sra",       6'h09, 32'h8000_0010, 32'h24,         32'hF800_0001,  0, 0, 0});
    vecs.push_back('{"srl",       6'h08, 32'h8000_0010, 32'h24,         32'h0800_0001,  0, 0, 0});
    vecs.push_back('{"sll",       6'h07, 32'h8000_0010, 32'h24,         32'h0000_0100,  0, 0, 0});
    vecs.push_back('{"slt",       6'h0A, 32'hFFFF_FFFF, 32'h1,          32'h1,          0, 0, 0});
    vecs.push_back('{"sltu",      6'h0B, 32'hFFFF_FFFF, 32'h1,          32'h0,          1, 0, 0});
    vecs.push_back('{"lui",       6'h0C, 32'h0,         32'h0000_1234,  32'h1234_0000,  0, 0, 0});
    vecs.push_back('{"ldw",       6'h10, 32'h100,       32'hFFFF_FFFC,  32'hFC,         0, 1, 0});
    vecs.push_back('{"sdw",       6'h11, 32'h100,       32'hFFFF_FFFC,  32'hFC,         0, 1, 0});
    vecs.push_back('{"unk3f",     6'h3F, 32'h1234_5678, 32'h9ABC_DEF0,  32'h0,          1, 0, 0});
    vecs.push_back('{"nop",       6'h00, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'h0,          1, 0, 0});
    vecs.push_back('{"nor",       6'h06, 32'hF0F0_0000, 32'h0F0F_0000,  32'h0000_FFFF,  0, 0, 0});
    vecs.push_back('{"and_zero",  6'h03, 32'hAAAA_AAAA, 32'h5555_5555,  32'h0,          1, 0, 0});
    vecs.push_back('{"sra_by31",  6'h09, 32'h8000_0000, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  0, 0, 0});
    vecs.push_back('{"sub_eq",    6'h02, 32'h7,         32'h7,          32'h0,          1, 0, 0});

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].op, vecs[i].a, vecs[i].b);
      #1 chk_live(vecs[i].name, vecs[i].exp_out, vecs[i].exp_zf, vecs[i].exp_cf, vecs[i].exp_of);
    end

    // ADD wrap: flags captured one edge later.
    @(negedge clk);
    drive(6'h01, 32'hFFFF_FFFF, 32'h1);
    @(posedge clk);
    #1 chk_reg("add_wrap_q", 1'b1, 1'b1, 1'b0);

    // Randomized vectors against the model, including the registered copy.
    valid_ops = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
                  6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h10, 6'h11};
    for (int i = 0; i < 300; i++) begin
      op = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                       : valid_ops[$urandom_range(0, 14)];
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: ra = 32'h8000_0000;
        1: rb = 32'h7FFF_FFFF;
        2: rb = ra;
        3: rb = -ra;
        default: ;
      endcase
      ref_model(op, ra, rb, r, c, o);
      @(negedge clk);
      drive(op, ra, rb);
      #1 chk_live($sformatf("rnd%0d_op%02h", i, op), r, (r == 32'h0), c, o);
      @(posedge clk);
      #1 chk_reg($sformatf("rnd%0d_q", i), (r == 32'h0), c, o);
    end

    // Asynchronous reset between edges while all flags are held at 1.
    @(negedge clk);
    drive(6'h01, 32'h8000_0000, 32'h8000_0000);
    @(posedge clk);
    #1 chk_reg("all_ones_q", 1'b1, 1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk_reg("async_clr", 1'b0, 1'b0, 1'b0);
    chk_live("live_in_reset", 32'h0, 1'b1, 1'b1, 1'b1);
    @(posedge clk);
    #1 chk_reg("held_in_reset", 1'b0, 1'b0, 1'b0);

    // Release mid-cycle with new operands; the next edge captures them.
    @(negedge clk);
    drive(6'h02, 32'h3, 32'h5);
    #1 rst_n = 1'b1;
    #1 chk_reg("post_release_pre_edge", 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 chk_reg("post_release_edge", 1'b0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
